lsu_ecc_scrub: RTL and testbench
================================

Name: lsu_ecc_scrub

Overview:
Downstream of the DC3 ECC check/correct stage. Captures single-bit-corrected DCCM words (per bank, hi/lo), re-encodes SECDED check bits and writes the repaired word back to DCCM through a request/grant handshake on the DCCM write port, which is shared with the store buffer drain. Double errors are never scrubbed. A small FIFO decouples error capture from write-port arbitration.

Parameters:
DEPTH, 4, scrub queue entries (power of 2, >=2)
ADDR_W, 16, DCCM byte-address width (`RV_DCCM_BITS)
DATA_W, 32, data bits per bank word
ECC_W, 7, SECDED check bits per bank word

Ports:
clk  in  1  core clock
rst_l  in  1  synchronous active-low reset
ecc_chk_valid_dc3  in  1  DC3 load/store to DCCM whose ECC result is valid
single_ecc_error_lo_dc3  in  1  SEC on lo bank
single_ecc_error_hi_dc3  in  1  SEC on hi bank
lsu_double_ecc_error_dc3  in  1  DED in either bank
dec_tlu_core_ecc_disable  in  1  blocks new captures
lsu_addr_dc3  in  ADDR_W  start address (lo-bank word)
end_addr_dc3  in  ADDR_W  end address (hi-bank word)
store_ecc_datafn_lo_dc3  in  DATA_W  corrected/merged lo word
store_ecc_datafn_hi_dc3  in  DATA_W  corrected/merged hi word
scrub_wr_gnt  in  1  DCCM write port granted this cycle
scrub_wr_req  out  1  scrub write request
scrub_wr_addr  out  ADDR_W  word-aligned address ([1:0]=0)
scrub_wr_data  out  DATA_W  write data
scrub_wr_ecc  out  ECC_W  check bits for scrub_wr_data
scrub_full  out  1  queue full
scrub_overflow  out  1  one-cycle pulse: capture dropped

Behaviour:
- Reset (rst_l=0 at posedge): queue empty, pointers 0, FSM IDLE; scrub_wr_req=0, scrub_wr_addr=0, scrub_wr_data=0, scrub_wr_ecc=0, scrub_full=0, scrub_overflow=0. Reset mid-request drops all queued entries with no write.
- Capture qualifier: cap = ecc_chk_valid_dc3 & ~dec_tlu_core_ecc_disable & ~lsu_double_ecc_error_dc3. Any DED blocks capture of both banks.
- cap & single_lo: enqueue {lsu_addr_dc3 & ~3, store_ecc_datafn_lo_dc3}. cap & single_hi: enqueue {end_addr_dc3 & ~3, store_ecc_datafn_hi_dc3}.
- Both in one cycle: lo enqueued first, then hi. Free slots counted after this cycle's pop. Entries that do not fit are dropped; scrub_overflow=1 the next cycle. Queue contents never corrupted on overflow.
- Enqueue and pop same cycle allowed; count = count + pushes - pop, range 0..DEPTH.
- scrub_full = (count == DEPTH), registered.
- Check bits: computed combinationally from head entry via rvecc_encode (same Hamming SECDED code as DCCM).
- FSM IDLE: queue non-empty -> REQ next cycle. A capture at edge N gives scrub_wr_req=1 from cycle N+1 (1-cycle latency).
- FSM REQ: scrub_wr_req=1; addr/data/ecc driven from head, held stable until grant. scrub_wr_gnt=1 -> write done that cycle, head popped. Queue still non-empty after pop -> stay REQ (back-to-back, next entry visible next cycle); else -> IDLE.
- scrub_wr_gnt while not in REQ: ignored.
- dec_tlu_core_ecc_disable rising while entries queued: queued entries still drain.
- Pointers wrap modulo DEPTH. No address coalescing: duplicate addresses are written twice, in order.

Optional Feature:
LSU_ECC_SCRUB_CNT_EN
- Defined: adds output scrub_cnt (16 bits), reset 0; +1 on every granted scrub write; saturates at 16'hFFFF. Adds input scrub_cnt_clr (1 bit); clr has priority over an increment in the same cycle (result 0).
- Undefined: no counter, no scrub_cnt or scrub_cnt_clr ports; all other behaviour identical.

Test Plan:
- Single lo SEC: valid, single_lo=1, lsu_addr=16'h0106, data_lo=32'hDEADBEEF, gnt tied 1 -> req=1 next cycle; addr=16'h0104, data=32'hDEADBEEF, ecc equals rvecc_encode(32'hDEADBEEF); req=0 the cycle after.
- Dual SEC: lsu_addr=16'h00FE, end_addr=16'h0101, both singles set, gnt held 0 for 5 cycles then 1 -> req stays 1 with addr 16'h00FC stable; then 16'h0100 next cycle; 2 writes total.
- DED/disable: both singles plus double=1 -> no request. Repeat with ecc_disable=1 and double=0 -> no request.
- Overflow: DEPTH=4, gnt=0, issue 5 single-lo captures -> scrub_full=1 after 4th; overflow pulse after 5th; draining yields exactly the first 4 in order.
- Reset mid-REQ: 2 entries queued, gnt=0, rst_l=0 one cycle -> req=0, full=0; no write after reset release.
- LSU_ECC_SCRUB_CNT_EN: 3 granted writes -> scrub_cnt=3; clr coincident with 4th grant -> scrub_cnt=0.

Source files
------------

// File: rtl/lsu_ecc_scrub.sv
// lsu_ecc_scrub: queues single-bit-corrected DCCM words and writes them back with fresh SECDED check bits.
// Optional build macro LSU_ECC_SCRUB_CNT_EN adds the granted-scrub counter (scrub_cnt, scrub_cnt_clr).
module lsu_ecc_scrub #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 16,
   parameter int DATA_W = 32,
   parameter int ECC_W  = 7
) (
   input  logic              clk,
   input  logic              rst_l,
   input  logic              ecc_chk_valid_dc3,
   input  logic              single_ecc_error_lo_dc3,
   input  logic              single_ecc_error_hi_dc3,
   input  logic              lsu_double_ecc_error_dc3,
   input  logic              dec_tlu_core_ecc_disable,
   input  logic [ADDR_W-1:0] lsu_addr_dc3,
   input  logic [ADDR_W-1:0] end_addr_dc3,
   input  logic [DATA_W-1:0] store_ecc_datafn_lo_dc3,
   input  logic [DATA_W-1:0] store_ecc_datafn_hi_dc3,
   input  logic              scrub_wr_gnt,
   output logic              scrub_wr_req,
   output logic [ADDR_W-1:0] scrub_wr_addr,
   output logic [DATA_W-1:0] scrub_wr_data,
   output logic [ECC_W-1:0]  scrub_wr_ecc,
   output logic              scrub_full,
   output logic              scrub_overflow
`ifdef LSU_ECC_SCRUB_CNT_EN
   ,
   input  logic              scrub_cnt_clr,
   output logic [15:0]       scrub_cnt
`endif
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
   localparam logic [ADDR_W-1:0] WORD_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      REQ  = 1'b1
   } state_t;

   // Hamming SECDED (39,32) check bits, identical to the DCCM encoder.
   function automatic logic [6:0] rvecc_encode(input logic [31:0] din);
      logic [6:0] ecc;
      ecc[0] = ^(din & 32'h56AA_AD5B);
      ecc[1] = ^(din & 32'h9B33_366D);
      ecc[2] = ^(din & 32'hE3C3_C78E);
      ecc[3] = ^(din & 32'h03FC_07F0);
      ecc[4] = ^(din & 32'h03FF_F800);
      ecc[5] = ^(din & 32'hFC00_0000);
      ecc[6] = ^{din, ecc[5:0]};
      return ecc;
   endfunction

   state_t            state_r;
   state_t            state_s;
   logic [ADDR_W-1:0] q_addr_r [DEPTH];
   logic [DATA_W-1:0] q_data_r [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_r;
   logic [PTR_W-1:0]  rd_ptr_r;
   logic [PTR_W-1:0]  hi_idx_s;
   logic [CNT_W-1:0]  count_r;
   logic [CNT_W-1:0]  count_s;
   logic [CNT_W-1:0]  free_s;
   logic              full_r;
   logic              ovf_r;
   logic              cap_s;
   logic              pop_s;
   logic              push_lo_s;
   logic              push_hi_s;
   logic              drop_s;
   logic              req_s;
   logic [ADDR_W-1:0] addr_s;
   logic [DATA_W-1:0] data_s;

   // Capture qualification and slot allocation; room is counted after this cycle's pop.
   always_comb begin
      cap_s     = ecc_chk_valid_dc3 & ~dec_tlu_core_ecc_disable & ~lsu_double_ecc_error_dc3;
      pop_s     = (state_r == REQ) & scrub_wr_gnt;
      free_s    = DEPTH_C - count_r + CNT_W'(pop_s);
      push_lo_s = cap_s & single_ecc_error_lo_dc3 & (free_s != {CNT_W{1'b0}});
      push_hi_s = cap_s & single_ecc_error_hi_dc3 & (free_s > CNT_W'(push_lo_s));
      drop_s    = (cap_s & single_ecc_error_lo_dc3 & ~push_lo_s) |
                  (cap_s & single_ecc_error_hi_dc3 & ~push_hi_s);
      hi_idx_s  = wr_ptr_r + PTR_W'(push_lo_s);
      count_s   = count_r + CNT_W'(push_lo_s) + CNT_W'(push_hi_s) - CNT_W'(pop_s);
   end

   // Queue storage; lo lands ahead of hi so lo is written back first.
   always_ff @(posedge clk) begin
      if (push_lo_s) begin
         q_addr_r[wr_ptr_r] <= lsu_addr_dc3 & WORD_MASK;
         q_data_r[wr_ptr_r] <= store_ecc_datafn_lo_dc3;
      end
      if (push_hi_s) begin
         q_addr_r[hi_idx_s] <= end_addr_dc3 & WORD_MASK;
         q_data_r[hi_idx_s] <= store_ecc_datafn_hi_dc3;
      end
   end

   // Pointers, occupancy and status flags.
   always_ff @(posedge clk) begin
      if (!rst_l) begin
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         count_r  <= {CNT_W{1'b0}};
         full_r   <= 1'b0;
         ovf_r    <= 1'b0;
      end else begin
         wr_ptr_r <= wr_ptr_r + PTR_W'(push_lo_s) + PTR_W'(push_hi_s);
         rd_ptr_r <= rd_ptr_r + PTR_W'(pop_s);
         count_r  <= count_s;
         full_r   <= (count_s == DEPTH_C);
         ovf_r    <= drop_s;
      end
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (!rst_l) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // FSM next state and write-port drive; the head is held until granted.
   always_comb begin
      state_s = state_r;
      req_s   = 1'b0;
      addr_s  = {ADDR_W{1'b0}};
      data_s  = {DATA_W{1'b0}};
      case (state_r)
         IDLE: begin
            if (count_s != {CNT_W{1'b0}}) begin
               state_s = REQ;
            end else begin
               state_s = IDLE;
            end
         end
         REQ: begin
            req_s  = 1'b1;
            addr_s = q_addr_r[rd_ptr_r];
            data_s = q_data_r[rd_ptr_r];
            if (count_s == {CNT_W{1'b0}}) begin
               state_s = IDLE;
            end else begin
               state_s = REQ;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   assign scrub_wr_req   = req_s;
   assign scrub_wr_addr  = addr_s;
   assign scrub_wr_data  = data_s;
   assign scrub_wr_ecc   = rvecc_encode(data_s);
   assign scrub_full     = full_r;
   assign scrub_overflow = ovf_r;

`ifdef LSU_ECC_SCRUB_CNT_EN
   logic [15:0] cnt_r;

   // Saturating count of granted scrub writes; clear wins over increment.
   always_ff @(posedge clk) begin
      if (!rst_l) begin
         cnt_r <= 16'h0000;
      end else if (scrub_cnt_clr) begin
         cnt_r <= 16'h0000;
      end else if (pop_s && (cnt_r != 16'hFFFF)) begin
         cnt_r <= cnt_r + 16'h0001;
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign scrub_cnt = cnt_r;
`endif

endmodule

// File: tb/tb_lsu_ecc_scrub.sv
// Self-checking bench for lsu_ecc_scrub: directed vector table, hand sequences, then random
// stimulus against a queue-based reference model. Define LSU_ECC_SCRUB_CNT_EN to cover the counter.
module tb_lsu_ecc_scrub;

   localparam int DEPTH = 4;

   logic        clk;
   logic        rst_l;
   logic        valid, lo, hi, ded, dis, gnt;
   logic [15:0] addr, eaddr;
   logic [31:0] dlo, dhi;
   logic        scrub_wr_req;
   logic [15:0] scrub_wr_addr;
   logic [31:0] scrub_wr_data;
   logic [6:0]  scrub_wr_ecc;
   logic        scrub_full;
   logic        scrub_overflow;
`ifdef LSU_ECC_SCRUB_CNT_EN
   logic        scrub_cnt_clr;
   logic [15:0] scrub_cnt;
   logic [15:0] m_cnt;
`endif

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic        v, l, h, d, x, g;
      logic [15:0] a, ea;
      logic [31:0] dl, dh;
      logic        er;
      logic [15:0] eadr;
      logic [31:0] edat;
      logic        ef, eo;
   } vec_t;

   vec_t        tbl[$];
   logic [15:0] mq_a[$];
   logic [31:0] mq_d[$];
   logic        m_ovf;

   lsu_ecc_scrub #(.DEPTH(DEPTH), .ADDR_W(16), .DATA_W(32), .ECC_W(7)) dut (
      .clk                     (clk),
      .rst_l                   (rst_l),
      .ecc_chk_valid_dc3       (valid),
      .single_ecc_error_lo_dc3 (lo),
      .single_ecc_error_hi_dc3 (hi),
      .lsu_double_ecc_error_dc3(ded),
      .dec_tlu_core_ecc_disable(dis),
      .lsu_addr_dc3            (addr),
      .end_addr_dc3            (eaddr),
      .store_ecc_datafn_lo_dc3 (dlo),
      .store_ecc_datafn_hi_dc3 (dhi),
      .scrub_wr_gnt            (gnt),
      .scrub_wr_req            (scrub_wr_req),
      .scrub_wr_addr           (scrub_wr_addr),
      .scrub_wr_data           (scrub_wr_data),
      .scrub_wr_ecc            (scrub_wr_ecc),
      .scrub_full              (scrub_full),
      .scrub_overflow          (scrub_overflow)
`ifdef LSU_ECC_SCRUB_CNT_EN
      ,
      .scrub_cnt_clr           (scrub_cnt_clr),
      .scrub_cnt               (scrub_cnt)
`endif
   );

   always #5 clk = ~clk;

   // Check bits from codeword positions: data fills non-power-of-two slots 3..38.
   function automatic logic [6:0] ref_ecc(input logic [31:0] d);
      logic [6:0] c;
      int k;
      c = 7'd0;
      k = 0;
      for (int pos = 1; pos <= 38; pos++) begin
         if ((pos & (pos - 1)) != 0) begin
            if (d[k]) c[5:0] = c[5:0] ^ pos[5:0];
            k++;
         end
      end
      c[6] = (^d) ^ (^c[5:0]);
      return c;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic chk_out(input string n, input logic er, input logic [15:0] ea,
                          input logic [31:0] ed, input logic ef, input logic eo);
      chk({n, ".req"},  64'(scrub_wr_req),   64'(er));
      chk({n, ".addr"}, 64'(scrub_wr_addr),  64'(ea));
      chk({n, ".data"}, 64'(scrub_wr_data),  64'(ed));
      chk({n, ".ecc"},  64'(scrub_wr_ecc),   64'(ref_ecc(ed)));
      chk({n, ".full"}, 64'(scrub_full),     64'(ef));
      chk({n, ".ovf"},  64'(scrub_overflow), 64'(eo));
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic l, input logic h, input logic d, input logic x,
                        input logic [15:0] a, input logic [15:0] ea, input logic [31:0] dl,
                        input logic [31:0] dh, input logic g);
      valid = v; lo = l; hi = h; ded = d; dis = x;
      addr = a; eaddr = ea; dlo = dl; dhi = dh; gnt = g;
   endtask

   task automatic add(input logic v, input logic l, input logic h, input logic d, input logic x,
                      input logic [15:0] a, input logic [15:0] ea, input logic [31:0] dl,
                      input logic [31:0] dh, input logic g, input logic er, input logic [15:0] eadr,
                      input logic [31:0] edat, input logic ef, input logic eo);
      vec_t t;
      t.v = v; t.l = l; t.h = h; t.d = d; t.x = x; t.a = a; t.ea = ea; t.dl = dl; t.dh = dh;
      t.g = g; t.er = er; t.eadr = eadr; t.edat = edat; t.ef = ef; t.eo = eo;
      tbl.push_back(t);
   endtask

   // Reference model: one clock edge, from the rules (pop head on grant, append lo then hi if room).
   task automatic model_edge();
      int room;
      logic cap, drop, granted;
      if (!rst_l) begin
         mq_a.delete();
         mq_d.delete();
         m_ovf = 1'b0;
`ifdef LSU_ECC_SCRUB_CNT_EN
         m_cnt = 16'h0000;
`endif
      end else begin
         granted = (mq_a.size() != 0) && gnt;
         if (granted) begin
            void'(mq_a.pop_front());
            void'(mq_d.pop_front());
         end
`ifdef LSU_ECC_SCRUB_CNT_EN
         if (scrub_cnt_clr) m_cnt = 16'h0000;
         else if (granted && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'h0001;
`endif
         cap  = valid && !dis && !ded;
         room = DEPTH - mq_a.size();
         drop = 1'b0;
         if (cap && lo) begin
            if (room > 0) begin
               mq_a.push_back({addr[15:2], 2'b00});
               mq_d.push_back(dlo);
               room--;
            end else drop = 1'b1;
         end
         if (cap && hi) begin
            if (room > 0) begin
               mq_a.push_back({eaddr[15:2], 2'b00});
               mq_d.push_back(dhi);
            end else drop = 1'b1;
         end
         m_ovf = drop;
      end
   endtask

   task automatic chk_model(input string n);
      logic er;
      er = (mq_a.size() != 0);
      chk_out(n, er, er ? mq_a[0] : 16'h0000, er ? mq_d[0] : 32'h0000_0000,
              mq_a.size() == DEPTH, m_ovf);
`ifdef LSU_ECC_SCRUB_CNT_EN
      chk({n, ".cnt"}, 64'(scrub_cnt), 64'(m_cnt));
`endif
   endtask

   initial begin
      clk = 1'b0;
      rst_l = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 32'h0, 32'h0, 1'b0);
`ifdef LSU_ECC_SCRUB_CNT_EN
      scrub_cnt_clr = 1'b0;
`endif
      step();
      step();
      chk_out("reset", 1'b0, 16'h0, 32'h0, 1'b0, 1'b0);
`ifdef LSU_ECC_SCRUB_CNT_EN
      chk("reset.cnt", 64'(scrub_cnt), 64'd0);
`endif
      rst_l = 1'b1;
      step();

      // single lo, gnt tied high
      add(1,1,0,0,0, 16'h0106,16'h0000, 32'hDEADBEEF,32'h0, 1, 1,16'h0104,32'hDEADBEEF,0,0);
      add(0,0,0,0,0, 16'h0000,16'h0000, 32'h0,32'h0,        1, 0,16'h0000,32'h0,0,0);
      // dual SEC, grant held off five cycles
      add(1,1,1,0,0, 16'h00FE,16'h0101, 32'h11111111,32'h22222222, 0, 1,16'h00FC,32'h11111111,0,0);
      for (int k = 0; k < 4; k++)
         add(0,0,0,0,0, 16'h0,16'h0, 32'h0,32'h0, 0, 1,16'h00FC,32'h11111111,0,0);
      add(0,0,0,0,0, 16'h0,16'h0, 32'h0,32'h0, 1, 1,16'h0100,32'h22222222,0,0);
      add(0,0,0,0,0, 16'h0,16'h0, 32'h0,32'h0, 1, 0,16'h0000,32'h0,0,0);
      // DED blocks both banks, disable blocks, no valid no capture
      add(1,1,1,1,0, 16'h0200,16'h0203, 32'h33333333,32'h44444444, 1, 0,16'h0,32'h0,0,0);
      add(1,1,1,0,1, 16'h0200,16'h0203, 32'h33333333,32'h44444444, 1, 0,16'h0,32'h0,0,0);
      add(0,1,1,0,0, 16'h0200,16'h0203, 32'h33333333,32'h44444444, 1, 0,16'h0,32'h0,0,0);
      // disable rising with an entry queued still drains it
      add(1,1,0,0,0, 16'h2003,16'h0, 32'hA5A5A5A5,32'h0, 0, 1,16'h2000,32'hA5A5A5A5,0,0);
      add(1,1,0,0,1, 16'h3000,16'h0, 32'h5A5A5A5A,32'h0, 0, 1,16'h2000,32'hA5A5A5A5,0,0);
      add(0,0,0,0,1, 16'h0,16'h0, 32'h0,32'h0,             1, 0,16'h0,32'h0,0,0);
      // duplicate word address written twice, in order
      add(1,1,1,0,0, 16'h0040,16'h0041, 32'h01020304,32'h05060708, 1, 1,16'h0040,32'h01020304,0,0);
      add(0,0,0,0,0, 16'h0,16'h0, 32'h0,32'h0, 1, 1,16'h0040,32'h05060708,0,0);
      add(0,0,0,0,0, 16'h0,16'h0, 32'h0,32'h0, 1, 0,16'h0,32'h0,0,0);

      foreach (tbl[i]) begin
         drive(tbl[i].v, tbl[i].l, tbl[i].h, tbl[i].d, tbl[i].x, tbl[i].a, tbl[i].ea,
               tbl[i].dl, tbl[i].dh, tbl[i].g);
         step();
         chk_out($sformatf("vec%0d", i), tbl[i].er, tbl[i].eadr, tbl[i].edat, tbl[i].ef, tbl[i].eo);
      end

      // overflow: five captures into a four-deep queue with no grant
      for (int i = 0; i < 5; i++) begin
         drive(1, 1, 0, 0, 0, 16'h0011 + 16'(4 * i), 16'h0, 32'hC0DE0000 + 32'(i), 32'h0, 0);
         step();
         chk_out($sformatf("ovf_fill%0d", i), 1'b1, 16'h0010, 32'hC0DE0000, i >= 3, i == 4);
      end
      drive(0, 0, 0, 0, 0, 16'h0, 16'h0, 32'h0, 32'h0, 0);
      step();
      chk_out("ovf_after", 1'b1, 16'h0010, 32'hC0DE0000, 1'b1, 1'b0);
      for (int j = 1; j <= 4; j++) begin
         gnt = 1'b1;
         step();
         if (j < 4) chk_out($sformatf("ovf_drain%0d", j), 1'b1, 16'h0010 + 16'(4 * j),
                            32'hC0DE0000 + 32'(j), 1'b0, 1'b0);
         else       chk_out("ovf_drain_end", 1'b0, 16'h0, 32'h0, 1'b0, 1'b0);
      end

      // reset while requesting drops everything
      drive(1, 1, 1, 0, 0, 16'h0080, 16'h0084, 32'h77777777, 32'h88888888, 0);
      step();
      chk_out("rst_pre", 1'b1, 16'h0080, 32'h77777777, 1'b0, 1'b0);
      drive(0, 0, 0, 0, 0, 16'h0, 16'h0, 32'h0, 32'h0, 0);
      rst_l = 1'b0;
      step();
      chk_out("rst_mid", 1'b0, 16'h0, 32'h0, 1'b0, 1'b0);
      rst_l = 1'b1;
      gnt = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         chk_out($sformatf("rst_post%0d", k), 1'b0, 16'h0, 32'h0, 1'b0, 1'b0);
      end

`ifdef LSU_ECC_SCRUB_CNT_EN
      chk("cnt_rst", 64'(scrub_cnt), 64'd0);
      drive(1, 1, 1, 0, 0, 16'h0300, 16'h0304, 32'h1, 32'h2, 0);
      step();
      step();
      drive(0, 0, 0, 0, 0, 16'h0, 16'h0, 32'h0, 32'h0, 1);
      step();
      step();
      step();
      chk("cnt_three", 64'(scrub_cnt), 64'd3);
      scrub_cnt_clr = 1'b1;
      step();
      scrub_cnt_clr = 1'b0;
      chk("cnt_clr", 64'(scrub_cnt), 64'd0);
      chk("cnt_clr_req", 64'(scrub_wr_req), 64'd0);
      gnt = 1'b0;
`endif

      // random traffic against the reference model
      rst_l = 1'b0;
      model_edge();
      step();
      rst_l = 1'b1;
      for (int c = 0; c < 3000; c++) begin
         drive(($urandom % 4) != 0, $urandom % 2, $urandom % 2, ($urandom % 8) == 0,
               ($urandom % 8) == 0, 16'($urandom), 16'($urandom), $urandom, $urandom,
               ((c / 200) % 2 == 0) ? (($urandom % 4) == 0) : (($urandom % 4) != 0));
         rst_l = ($urandom % 300) != 0;
`ifdef LSU_ECC_SCRUB_CNT_EN
         scrub_cnt_clr = ($urandom % 32) == 0;
`endif
         model_edge();
         step();
         chk_model($sformatf("rnd%0d", c));
      end
      rst_l = 1'b1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
